// File: rtl/hazard_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared state encoding and hazard-compare helper for the stall unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT_ERR = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero is never a real producer, so a load targeting it cannot create a hazard.
  function automatic logic load_use_hit(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_mem_wait_timer.sv
// ============================================================================
// Module   : hazard_mem_wait_timer
// Purpose  : Counts consecutive data-memory wait cycles; flags the last allowed one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int              CW   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]   LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0]   MAX  = CW'(MEM_TIMEOUT);

  logic [CW-1:0] count;

  // Saturates at MEM_TIMEOUT so a parked counter can never wrap back into range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ============================================================================
// Module   : hazard_stall_unit
// Purpose  : Load-use / branch / slow-memory pipeline control with memory watchdog.
//            Optional perf counters enabled by HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_reg_rs,
  input  logic [4:0]  ID_reg_rt,
  input  logic        ID_uses_rt,
  input  logic        EX_mem_read,
  input  logic [4:0]  EX_reg_rt,
  input  logic        EX_branch_taken,
  input  logic        MEM_mem_req,
  input  logic        MEM_mem_ready,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        EX_MEM_write,
  output logic        MEM_WB_flush,
  output logic        mem_error,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       timer_clr;
  logic       timer_inc;
  logic       timer_expired;
  logic       mem_stall;
  logic       load_use;

  hazard_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    case (state)
      RUN: begin
        if (MEM_mem_req && !MEM_mem_ready) begin
          state_nxt = MEM_WAIT;
          timer_inc = 1'b1;
        end else begin
          timer_clr = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (MEM_mem_ready) begin
          state_nxt = RUN;
          timer_clr = 1'b1;
        end else begin
          timer_inc = 1'b1;
          if (timer_expired) state_nxt = HALT_ERR;
        end
      end
      HALT_ERR: state_nxt = HALT_ERR;
      default: begin
        state_nxt = RUN;
        timer_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // The release cycle of MEM_WAIT is not a stall: the pipe advances and lower priorities apply.
  assign mem_stall = (state == HALT_ERR) ||
                     ((state == MEM_WAIT) && !MEM_mem_ready) ||
                     ((state == RUN) && MEM_mem_req && !MEM_mem_ready);

  assign load_use = load_use_hit(EX_mem_read, EX_reg_rt, ID_reg_rs, ID_reg_rt, ID_uses_rt);

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_write = 1'b1;
    MEM_WB_flush = 1'b0;
    if (mem_stall) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_flush = 1'b1;
    end else if (EX_branch_taken) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      PC_write     = 1'b1;
    end else if (load_use) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_flush  = 1'b1;
    end
  end

  assign mem_error = (state == HALT_ERR);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (IF_ID_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_count  = flush_cnt;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// Module   : tb_hazard_stall_unit
// Purpose  : Directed scoreboard bench for hazard_stall_unit (HAZARD_PERF_CNT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_reg_rs, ID_reg_rt, EX_reg_rt;
  logic        ID_uses_rt, EX_mem_read, EX_branch_taken, MEM_mem_req, MEM_mem_ready;
  logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write, MEM_WB_flush, mem_error;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  hazard_stall_unit #(.MEM_TIMEOUT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .ID_reg_rs       (ID_reg_rs),
    .ID_reg_rt       (ID_reg_rt),
    .ID_uses_rt      (ID_uses_rt),
    .EX_mem_read     (EX_mem_read),
    .EX_reg_rt       (EX_reg_rt),
    .EX_branch_taken (EX_branch_taken),
    .MEM_mem_req     (MEM_mem_req),
    .MEM_mem_ready   (MEM_mem_ready),
    .PC_write        (PC_write),
    .IF_ID_write     (IF_ID_write),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_flush     (ID_EX_flush),
    .EX_MEM_write    (EX_MEM_write),
    .MEM_WB_flush    (MEM_WB_flush),
    .mem_error       (mem_error),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  always #5 clk = ~clk;

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write, MEM_WB_flush, mem_error}
  localparam logic [6:0] DEF  = 7'b1100100;
  localparam logic [6:0] LU   = 7'b0001100;
  localparam logic [6:0] BR   = 7'b1111100;
  localparam logic [6:0] MS   = 7'b0000010;
  localparam logic [6:0] HE   = 7'b0000011;

  logic [6:0]  outs;
  assign outs = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write, MEM_WB_flush, mem_error};

  logic [6:0]  exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] stall_exp = 0;
  logic [31:0] flush_exp = 0;

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic mr,
                       input logic [4:0] ert, input logic br, input logic req, input logic rdy);
    ID_reg_rs = rs; ID_reg_rt = rt; ID_uses_rt = urt; EX_mem_read = mr;
    EX_reg_rt = ert; EX_branch_taken = br; MEM_mem_req = req; MEM_mem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_now(input string tag, input logic [6:0] exp);
    logic [6:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    tests++;
    assert (outs === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, outs, e);
    end
`ifdef HAZARD_PERF_CNT_EN
    if (!reset && !e[6]) stall_exp++;
    if (!reset && e[4])  flush_exp++;
`endif
  endtask

  // Entered at posedge+1; samples at posedge+4, returns at the next posedge+1.
  task automatic step(input string tag, input logic [6:0] exp);
    #3;
    check_now(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_perf(input string tag);
    cmp({tag, "_stall"}, stall_cycles, stall_exp);
    cmp({tag, "_flush"}, {16'd0, flush_count}, flush_exp);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step("reset_outs", DEF);
    chk_perf("reset");
    reset = 1'b0;

    // load-use on rs, then the load has left EX
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    step("lu_rs", LU);
    idle();
    step("lu_release", DEF);

    // $zero destination and unused rt never stall; a used rt does
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step("lu_zero", DEF);
    drive(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    step("lu_rt_unused", DEF);
    drive(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    step("lu_rt_used", LU);

    // taken branch overrides load-use
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    step("br_over_lu", BR);
    idle();
    step("after_br", DEF);
    chk_perf("after_br");

    // slow memory: three frozen cycles (branch hidden), release lets load-use through
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("mem_wait1", MS);
    step("mem_wait2", MS);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step("stall_hides_br", MS);
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1);
    step("release_lu", LU);
    idle();
    step("run_again", DEF);
    chk_perf("after_mem");

    // watchdog: 16 not-ready cycles tolerated, then sticky error
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step("tmo_wait", MS);
    step("halt", HE);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    step("halt_sticky", HE);
    chk_perf("halt");

    reset = 1'b1;
    stall_exp = 0;
    flush_exp = 0;
    idle();
    #1;
    check_now("rst_from_halt", DEF);
    chk_perf("rst_from_halt");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_halt_run", DEF);

    // asynchronous reset in the middle of a MEM_WAIT cycle
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("pre_rst_wait1", MS);
    step("pre_rst_wait2", MS);
    #2;
    reset = 1'b1;
    idle();
    stall_exp = 0;
    flush_exp = 0;
    #1;
    check_now("rst_mid_wait", DEF);
    chk_perf("rst_mid_wait");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_rst_run", DEF);

    // a cleared wait counter grants the full 16-cycle allowance again
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step("tmo2_wait", MS);
    step("halt2", HE);
    chk_perf("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
